// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the Booth multiplier and the
// signed test-sequence counter that feeds it.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEF = 5;

  // Sweep range of the upstream signed counter
  localparam int CNT_MIN = -7;
  localparam int CNT_MAX = 7;

endpackage

// File: rtl/seq_booth_mult_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M selected by
// {Q[0], q_m1}, then arithmetic shift right of {acc, Q, q_m1}.
module booth_step #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH:0]   m,
  input  logic [WIDTH-1:0] q,
  input  logic             q_m1,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_m1_next
);

  logic [WIDTH:0] sum;

  // Booth recoding of the current multiplier bit pair
  always_comb begin
    sum = acc;
    case ({q[0], q_m1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  assign acc_next  = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next    = {sum[0], q[WIDTH-1:1]};
  assign q_m1_next = q[0];

endmodule

// File: rtl/seq_booth_mult.sv
// Sequential radix-2 Booth multiplier with valid/ready on both sides;
// one operand pair in flight, product held until the consumer takes it.
module seq_booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t          state;
  logic [WIDTH:0]  acc;
  logic [WIDTH:0]  m;
  logic [WIDTH:0]  acc_next;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic            q_m1;
  logic            q_m1_next;
  logic [CW-1:0]   cnt;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc       (acc),
    .m         (m),
    .q         (q),
    .q_m1      (q_m1),
    .acc_next  (acc_next),
    .q_next    (q_next),
    .q_m1_next (q_m1_next)
  );

  // Control FSM and datapath registers; M carries an extra sign bit so
  // negating the most negative operand stays exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      product   <= '0;
      acc       <= '0;
      m         <= '0;
      q         <= '0;
      q_m1      <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m        <= {a[WIDTH-1], a};
            q        <= b;
            acc      <= '0;
            q_m1     <= 1'b0;
            cnt      <= CW'(WIDTH);
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          acc  <= acc_next;
          q    <= q_next;
          q_m1 <= q_m1_next;
          cnt  <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            product   <= {acc_next[WIDTH-1:0], q_next};
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_booth_mult.sv
// Directed bench for seq_booth_mult: vector table, counter sweep,
// back-pressure and mid-operation reset sequences.
module tb_seq_booth_mult;
  import mult_pkg::*;

  localparam int W = 5;

  typedef struct {
    int a;
    int b;
    int p;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;

  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   ov_rises = 0;
  logic ov_prev  = 1'b0;

  vec_t vecs[8];

  seq_booth_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // out_valid and in_ready must never be high together; also count product events
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (out_valid && in_ready) begin
        errors++;
        $display("FAIL exclusive: out_valid=%0b in_ready=%0b at cycle %0d", out_valid, in_ready, cyc);
      end
    end
    if (out_valid && !ov_prev) ov_rises++;
    ov_prev = out_valid;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, " ready"}, int'(in_ready), 1);
  endtask

  // Present a pair at a negedge, accept on the next edge, then wait for out_valid
  task automatic accept_and_wait(input int va, input int vb, output int lat);
    in_valid = 1'b1;
    a = va[W-1:0];
    b = vb[W-1:0];
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~va[W-1:0];
    b = ~vb[W-1:0];
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic mult_once(input string name, input int va, input int vb, input int exp);
    int lat;
    wait_ready(name);
    accept_and_wait(va, vb, lat);
    check({name, " latency"}, lat, W);
    check({name, " product"}, int'($signed(product)), exp);
    check({name, " in_ready"}, int'(in_ready), 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({name, " ov_drop"}, int'(out_valid), 0);
    check({name, " ir_back"}, int'(in_ready), 1);
  endtask

  initial begin
    int lat;
    int last_cyc;
    int rises0;

    vecs[0] = '{a:   7, b:  -7, p:  -49};
    vecs[1] = '{a: -16, b: -16, p:  256};
    vecs[2] = '{a: -16, b:  15, p: -240};
    vecs[3] = '{a:   0, b:   0, p:    0};
    vecs[4] = '{a:  15, b:  15, p:  225};
    vecs[5] = '{a:  -1, b:   1, p:   -1};
    vecs[6] = '{a:   1, b: -16, p:  -16};
    vecs[7] = '{a:  15, b: -16, p: -240};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_valid", int'(out_valid), 0);
    check("reset in_ready", int'(in_ready), 1);
    check("reset product", int'(product), 0);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      mult_once($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
    end

    // Counter sweep against b=3 with out_ready held high
    out_ready = 1'b1;
    rises0 = ov_rises;
    last_cyc = 0;
    for (int k = CNT_MIN; k <= CNT_MAX; k++) begin
      wait_ready($sformatf("sweep%0d", k));
      accept_and_wait(k, 3, lat);
      check($sformatf("sweep%0d latency", k), lat, W);
      check($sformatf("sweep%0d product", k), int'($signed(product)), 3 * k);
      if (k != CNT_MIN) check($sformatf("sweep%0d spacing", k), cyc - last_cyc, W + 2);
      last_cyc = cyc;
    end
    @(negedge clk);
    @(negedge clk);
    check("sweep count", ov_rises - rises0, CNT_MAX - CNT_MIN + 1);
    out_ready = 1'b0;

    // Back-pressure: product held for 10 cycles, in_valid pulses ignored
    wait_ready("bp");
    accept_and_wait(-3, 5, lat);
    check("bp latency", lat, W);
    check("bp product", int'($signed(product)), -15);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2) == 0;
      a = 5'd7;
      b = 5'd7;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp hold%0d product", i), int'($signed(product)), -15);
      check($sformatf("bp hold%0d out_valid", i), int'(out_valid), 1);
      check($sformatf("bp hold%0d in_ready", i), int'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp release in_ready", int'(in_ready), 1);
    check("bp release out_valid", int'(out_valid), 0);
    mult_once("bp after", 4, -4, -16);

    // Reset on the 3rd CALC cycle aborts the pair
    wait_ready("rst");
    rises0 = ov_rises;
    in_valid = 1'b1;
    a = 5'd3;
    b = 5'd3;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst out_valid", int'(out_valid), 0);
    check("rst in_ready", int'(in_ready), 1);
    check("rst product", int'(product), 0);
    repeat (8) @(negedge clk);
    check("rst no product", ov_rises - rises0, 0);
    mult_once("rst next", 0, -5, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_booth_mult.md
# seq_booth_mult

Sequential radix-2 Booth multiplier for signed two's-complement operands. It sits directly downstream of the signed test-sequence counter, which sweeps −7…+7. It consumes one operand pair per valid/ready handshake and returns a full-width signed product after a fixed number of iterations. The product is then fed to the display/compare stage of the lab datapath.

## Interface
Parameters:
- WIDTH, 5, operand width in bits; product is 2·WIDTH bits; legal range 2–16.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair a/b is valid.
- in_ready  out  1  block can accept an operand pair.
- a  in  WIDTH  multiplicand, signed.
- b  in  WIDTH  multiplier, signed.
- out_valid  out  1  product is valid and held stable.
- out_ready  in  1  consumer accepts the product.
- product  out  2·WIDTH  signed a·b, exact, never saturated.

## Operation
- FSM states: IDLE, CALC, DONE. The reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - If in_valid, at that edge: latch M = sign-extended a (WIDTH+1 bits), Q = b, acc = 0, q_m1 = 0, cnt = WIDTH. Then go to CALC.
- CALC:
  - in_ready = 0. Each cycle performs one Booth step on {Q[0], q_m1}:
    - 01: acc += M.
    - 10: acc −= M.
    - 00/11: no add.
  - Then arithmetic-shift-right {acc, Q, q_m1} by one. Decrement cnt.
  - When cnt reaches 1 (the last step), register product = {acc, Q}[2·WIDTH−1:0] and go to DONE.
- DONE:
  - out_valid = 1. product is held constant until out_ready is seen high at a clock edge; then go to IDLE.
- Width rule: acc and M are WIDTH+1 bits. This makes negation of −2^(WIDTH−1) exact; e.g. −16·−16 = +256 fits in 10-bit signed.
- in_valid during CALC or DONE is ignored; no input buffering, no pipelining.
- a and b are sampled only at the accept edge. Later changes to a or b have no effect.

## Timing
- Reset (rst high at an edge):
  - state = IDLE; out_valid = 0; product = 0; acc, Q, cnt = 0.
  - in_ready = 1 from the first cycle after reset.
  - rst overrides every other input.
- Reset mid-CALC or mid-DONE:
  - The operation is aborted and the product is discarded.
  - out_valid is never asserted for the aborted pair.
- Latency:
  - Accept edge T0.
  - out_valid rises after edge T0+WIDTH (5 cycles for WIDTH=5).
- Throughput:
  - With out_ready held high, one product every WIDTH+2 cycles.
  - in_ready returns in the cycle after the out handshake.
- out_valid and in_ready are never both 1.
- Simultaneous events:
  - out_ready high on the same edge out_valid first rises: no effect. Handshake requires out_valid already 1 before the edge.
  - The transition DONE→IDLE and a new accept cannot occur on the same edge.

## Structure
- Shared package mult_pkg:
  - state enum {IDLE, CALC, DONE}.
  - Default WIDTH constant (5).
  - Counter range constants CNT_MIN = −7 and CNT_MAX = 7, shared with the upstream counter and its testbench.
- One sub-module: booth_step.
  - Combinational: takes acc, M, Q, q_m1 and returns the next shifted {acc, Q, q_m1}.
  - It is instantiated once inside the FSM datapath.

## Test plan
- Reset, then a=7, b=−7 → out_valid 5 cycles after accept; product = −49 (10'h3CF).
- a=−16, b=−16 → product = +256 (10'h100).
- a=−16, b=15 → product = −240 (10'h310).
- Feed the counter sweep −7…7 against b=3 with out_ready=1:
  - 15 products, −21…21, each exactly WIDTH+2 cycles apart.
  - No pair is dropped or duplicated.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE.
  - product is stable and out_valid stays 1.
  - in_ready stays 0.
  - in_valid pulses are ignored.
  - Release out_ready → in_ready=1 on the next cycle.
- Assert rst on the 3rd CALC cycle, then accept a=0, b=−5.
  - out_valid is never asserted for the aborted pair.
  - The next product = 0.
  - Latency is unchanged.
